// File: rtl/pe_conv_ctrl.sv
// rtl/pe_conv_ctrl.sv - convolution loop controller for one PE; optional stall counter via PE_CTRL_PERF_EN
module pe_conv_ctrl #(
  parameter int CI_W  = 2,
  parameter int CO_W  = 2,
  parameter int KTAPS = 9,
  parameter int TAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_conv,
  input  logic             start_again,
  input  logic             abort,
  input  logic [CI_W-1:0]  cfg_ci,
  input  logic [CO_W-1:0]  cfg_co,
  input  logic             in_ready,
  output logic             ifm_read,
  output logic             wgt_read,
  output logic [TAP_W-1:0] tap_idx,
  output logic [CI_W-1:0]  ci_idx,
  output logic [CO_W-1:0]  co_idx,
  output logic             p_valid_output,
  output logic             last_chanel_output,
  output logic             end_conv,
  output logic             busy
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(KTAPS - 1);

  state_t            state, state_nxt;
  logic [CI_W-1:0]   ci_max;
  logic [CO_W-1:0]   co_max;
  logic              cfg_loaded;
  logic [TAP_W-1:0]  tap_cnt;
  logic [CI_W-1:0]   ci_cnt;
  logic [CO_W-1:0]   co_cnt;

  logic start_ok;
  logic beat;
  logic tap_last;
  logic ci_last;
  logic co_last;
  logic final_beat;

  // Handshake decode: a start is only honoured in IDLE without a same-cycle abort,
  // and abort suppresses the beat so no counter or flag advances on that cycle.
  always_comb begin
    start_ok   = 1'b0;
    beat       = 1'b0;
    tap_last   = (tap_cnt == TAP_MAX);
    ci_last    = (ci_cnt == ci_max);
    co_last    = (co_cnt == co_max);
    if (state == IDLE && !abort)
      start_ok = start_conv || (start_again && cfg_loaded);
    if (state == RUN && !abort)
      beat = in_ready;
    final_beat = beat && tap_last && ci_last && co_last;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and combinational outputs.
  always_comb begin
    state_nxt = state;
    ifm_read  = 1'b0;
    wgt_read  = 1'b0;
    end_conv  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = RUN;
      end
      RUN: begin
        ifm_read = in_ready;
        wgt_read = in_ready;
        if (abort)           state_nxt = IDLE;
        else if (final_beat) state_nxt = DONE;
      end
      DONE: begin
        end_conv  = !abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tap_idx = tap_cnt;
  assign ci_idx  = ci_cnt;
  assign co_idx  = co_cnt;

  // Configuration latch: only a fresh start_conv reloads the channel limits;
  // start_again reuses whatever was captured last time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ci_max     <= '0;
      co_max     <= '0;
      cfg_loaded <= 1'b0;
    end else if (state == IDLE && !abort && start_conv) begin
      ci_max     <= cfg_ci;
      co_max     <= cfg_co;
      cfg_loaded <= 1'b1;
    end
  end

  // Loop counters: tap innermost, then ci, then co; the final beat leaves them at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt <= '0;
      ci_cnt  <= '0;
      co_cnt  <= '0;
    end else if (start_ok) begin
      tap_cnt <= '0;
      ci_cnt  <= '0;
      co_cnt  <= '0;
    end else if (beat && !final_beat) begin
      if (!tap_last) begin
        tap_cnt <= tap_cnt + 1'b1;
      end else begin
        tap_cnt <= '0;
        if (!ci_last) begin
          ci_cnt <= ci_cnt + 1'b1;
        end else begin
          ci_cnt <= '0;
          co_cnt <= co_cnt + 1'b1;
        end
      end
    end
  end

  // Partial-sum flags trail the last-tap beat by one cycle for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_output     <= 1'b0;
      last_chanel_output <= 1'b0;
    end else begin
      p_valid_output     <= beat && tap_last;
      last_chanel_output <= beat && tap_last && ci_last;
    end
  end

`ifdef PE_CTRL_PERF_EN
  // Stall counter: RUN cycles without in_ready, saturating, cleared on each start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (start_ok)
      stall_cnt <= '0;
    else if (state == RUN && !in_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// tb/tb_pe_conv_ctrl.sv - scoreboard bench for pe_conv_ctrl
module tb_pe_conv_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_conv = 1'b0;
  logic       start_again = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] cfg_ci = '0;
  logic [1:0] cfg_co = '0;
  logic       in_ready = 1'b0;
  logic       ifm_read, wgt_read;
  logic [3:0] tap_idx;
  logic [1:0] ci_idx, co_idx;
  logic       p_valid_output, last_chanel_output, end_conv, busy;
`ifdef PE_CTRL_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] k1_stall_cnt;
`endif

  logic       k1_start = 1'b0;
  logic       k1_ifm_read, k1_wgt_read;
  logic [3:0] k1_tap_idx;
  logic [1:0] k1_ci_idx, k1_co_idx;
  logic       k1_p_valid, k1_last, k1_end, k1_busy;

  pe_conv_ctrl #(.CI_W(2), .CO_W(2), .KTAPS(9), .TAP_W(4)) u_dut (
    .clk(clk), .rst(rst), .start_conv(start_conv), .start_again(start_again),
    .abort(abort), .cfg_ci(cfg_ci), .cfg_co(cfg_co), .in_ready(in_ready),
    .ifm_read(ifm_read), .wgt_read(wgt_read), .tap_idx(tap_idx),
    .ci_idx(ci_idx), .co_idx(co_idx), .p_valid_output(p_valid_output),
    .last_chanel_output(last_chanel_output), .end_conv(end_conv), .busy(busy)
`ifdef PE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pe_conv_ctrl #(.CI_W(2), .CO_W(2), .KTAPS(1), .TAP_W(4)) u_k1 (
    .clk(clk), .rst(rst), .start_conv(k1_start), .start_again(1'b0),
    .abort(1'b0), .cfg_ci(2'd0), .cfg_co(2'd0), .in_ready(1'b1),
    .ifm_read(k1_ifm_read), .wgt_read(k1_wgt_read), .tap_idx(k1_tap_idx),
    .ci_idx(k1_ci_idx), .co_idx(k1_co_idx), .p_valid_output(k1_p_valid),
    .last_chanel_output(k1_last), .end_conv(k1_end), .busy(k1_busy)
`ifdef PE_CTRL_PERF_EN
    , .stall_cnt(k1_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  logic [7:0] beat_q[$];
  bit         pv_q[$];
  int         end_q = 0;
  logic [1:0] lat_ci = '0;
  logic [1:0] lat_co = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a beat, partial sum or done.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (ifm_read !== wgt_read) chk("rd_strobes_equal", {31'd0, wgt_read}, {31'd0, ifm_read});
      if (ifm_read) begin
        if (beat_q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
        else chk("beat_idx", {24'd0, tap_idx, ci_idx, co_idx}, {24'd0, beat_q.pop_front()});
      end
      if (p_valid_output) begin
        if (pv_q.size() == 0) chk("unexpected_pvalid", 32'd1, 32'd0);
        else chk("last_chanel", {31'd0, last_chanel_output}, {31'd0, pv_q.pop_front()});
      end else if (last_chanel_output) begin
        chk("last_without_pvalid", 32'd1, 32'd0);
      end
      if (end_conv) begin
        if (end_q == 0) chk("unexpected_end_conv", 32'd1, 32'd0);
        else begin
          end_q--;
          chk("end_with_pvalid", {30'd0, p_valid_output, busy}, 32'd3);
        end
      end
    end
  end

  task automatic push_run(input logic [1:0] ci, input logic [1:0] co, input bit aborted);
    for (int o = 0; o <= int'(co); o++)
      for (int c = 0; c <= int'(ci); c++) begin
        for (int t = 0; t < 9; t++) beat_q.push_back({t[3:0], c[1:0], o[1:0]});
        if (!(aborted && o == int'(co) && c == int'(ci))) pv_q.push_back(c == int'(ci));
      end
    if (!aborted) end_q++;
  endtask

  task automatic do_run(input bit again, input logic [1:0] ci, input logic [1:0] co,
                        input bit tog, input int abort_k, input int newcfg_k, input int exp_end_k);
    int  k;
    bit  done;
    if (!again) begin
      lat_ci = ci;
      lat_co = co;
    end
    push_run(lat_ci, lat_co, abort_k != 0);
    @(posedge clk); #1;
    start_conv  = !again;
    start_again = again;
    cfg_ci      = ci;
    cfg_co      = co;
    in_ready    = 1'b1;
    k = 0;
    done = 1'b0;
    while (!done && k < 400) begin
      @(posedge clk); #1;
      start_again = 1'b0;
      start_conv  = (k + 1 == newcfg_k);
      if (start_conv) begin
        cfg_ci = 2'd0;
        cfg_co = 2'd0;
      end
      abort = (abort_k != 0 && k + 1 == abort_k);
      if (tog) in_ready = ~in_ready;
      k++;
      @(negedge clk);
      if (abort_k == 0 && end_conv) begin
        done = 1'b1;
`ifdef PE_CTRL_PERF_EN
        chk("stall_cnt", {16'd0, stall_cnt}, tog ? 32'd54 : 32'd0);
`endif
      end
      if (abort_k != 0 && k == abort_k + 1) begin
        chk("abort_idle_next", {31'd0, busy}, 32'd0);
        done = 1'b1;
      end
    end
    start_conv = 1'b0;
    abort      = 1'b0;
    in_ready   = 1'b1;
    if (abort_k == 0) chk("end_latency", k, exp_end_k);
    repeat (3) @(negedge clk);
    chk("busy_after_run", {31'd0, busy}, 32'd0);
    chk("beat_q_empty", beat_q.size(), 32'd0);
    chk("pv_q_empty", pv_q.size(), 32'd0);
    chk("end_q_empty", end_q, 32'd0);
  endtask

  initial begin
    bit busy_seen;
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_outputs", {22'd0, ifm_read, wgt_read, p_valid_output, last_chanel_output, end_conv, busy,
                        tap_idx, ci_idx, co_idx}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Asynchronous reset mid-RUN, then start_again must be ignored.
    @(posedge clk); #1;
    start_conv = 1'b1; cfg_ci = 2'd1; cfg_co = 2'd2; in_ready = 1'b1;
    @(posedge clk); #1 start_conv = 1'b0;
    repeat (11) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {22'd0, ifm_read, wgt_read, p_valid_output, last_chanel_output, end_conv, busy,
                              tap_idx, ci_idx, co_idx}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;
    start_again = 1'b1;
    @(posedge clk); #1 start_again = 1'b0;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("again_ignored_no_cfg", {31'd0, busy_seen}, 32'd0);

    do_run(1'b0, 2'd1, 2'd2, 1'b0, 0, 0, 55);    // 54 beats, no stalls
    do_run(1'b0, 2'd1, 2'd2, 1'b1, 0, 0, 109);   // alternating in_ready
    do_run(1'b0, 2'd0, 2'd0, 1'b0, 0, 0, 10);    // single channel
    do_run(1'b0, 2'd1, 2'd2, 1'b0, 54, 0, 0);    // abort on the final beat
    do_run(1'b1, 2'd0, 2'd0, 1'b0, 0, 0, 55);    // replay latched 1/2 config
    do_run(1'b0, 2'd3, 2'd1, 1'b0, 0, 10, 73);   // new config mid-run ignored

    // KTAPS=1 instance: single beat then all completion flags together.
    mon_en = 1'b0;
    @(posedge clk); #1 k1_start = 1'b1;
    @(posedge clk); #1 k1_start = 1'b0;
    @(negedge clk);
    chk("k1_beat", {24'd0, k1_ifm_read, k1_wgt_read, k1_busy, k1_p_valid, k1_end,
                    k1_tap_idx == 4'd0, k1_ci_idx == 2'd0, k1_co_idx == 2'd0}, 32'hE7);
    @(negedge clk);
    chk("k1_done", {24'd0, k1_ifm_read, k1_p_valid, k1_last, k1_end, k1_busy, 3'd0}, 32'h78);
    @(negedge clk);
    chk("k1_idle", {31'd0, k1_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_conv_ctrl.md
# pe_conv_ctrl

Parametrised convolution controller for one processing element. It succeeds the fixed 2-bit PE FSM and generalises channel-counter widths and kernel tap count. It adds an input-ready stall handshake, an abort, a replay (`start_again`) using latched configuration, and exported loop indices for IFM/weight addressing. It sits between the layer sequencer (start/config) and the PE datapath and buffers (read strobes, partial-sum valid, end of convolution).

## Interface
Parameters:
- `CI_W`, default 2: width of `cfg_ci`; input channels = `cfg_ci`+1.
- `CO_W`, default 2: width of `cfg_co`; output channels = `cfg_co`+1.
- `KTAPS`, default 9: kernel taps per channel; must be ≥1 and ≤2^`TAP_W`.
- `TAP_W`, default 4: width of `tap_idx`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_conv` in 1: level/pulse; latches `cfg_ci`/`cfg_co` and starts when in IDLE.
- `start_again` in 1: restart with previously latched config when in IDLE.
- `abort` in 1: synchronous cancel.
- `cfg_ci` in CI_W: input-channel count minus 1.
- `cfg_co` in CO_W: output-channel count minus 1.
- `in_ready` in 1: IFM and weight buffers can supply a beat this cycle.
- `ifm_read` out 1: IFM read strobe (beat).
- `wgt_read` out 1: weight read strobe (beat).
- `tap_idx` out TAP_W, `ci_idx` out CI_W, `co_idx` out CO_W: indices of the current beat.
- `p_valid_output` out 1: partial sum for one channel complete.
- `last_chanel_output` out 1: qualifies `p_valid_output` for the last input channel.
- `end_conv` out 1: one-cycle done pulse.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN:
  - on `start_conv`=1: latch config, set `cfg_loaded`=1.
  - else on `start_again`=1 with `cfg_loaded`=1: reuse latched config.
  - `start_again` with `cfg_loaded`=0 is ignored.
  - `start_conv` wins if both are asserted.
- All counters are cleared on entry to RUN.
- RUN beat: `ifm_read`=`wgt_read`=`in_ready` (combinational, RUN only). Indices are valid whenever state is RUN.
- Loop order on each beat:
  - tap innermost, 0..KTAPS-1.
  - then ci, 0..cfg_ci.
  - then co outermost, 0..cfg_co.
  - Counters hold when `in_ready`=0.
- The beat with tap=KTAPS-1 registers `p_valid_output`=1 next cycle, with `last_chanel_output`=1 if ci was the latched max.
- The beat with tap, ci and co all at max moves the FSM to DONE.
- DONE: `end_conv`=1 for exactly one cycle, then IDLE.
- Total beats = KTAPS·(cfg_ci+1)·(cfg_co+1). Counters never wrap beyond their latched max.
- `start_conv`/`start_again` in RUN or DONE are ignored. Config inputs are sampled only at start.
- `abort` in RUN or DONE → IDLE next cycle.
  - Clears `p_valid_output`, `last_chanel_output` and the pending `end_conv`; no `end_conv` is produced.
  - `abort` has priority over `in_ready` and the final beat.
  - `abort` in IDLE has no effect, and a start in that same cycle is ignored.
  - `cfg_loaded` is retained.

## Timing
- Reset (async, any state):
  - state IDLE; all counters 0; `cfg_loaded`=0.
  - `ifm_read`=`wgt_read`=`p_valid_output`=`last_chanel_output`=`end_conv`=`busy`=0; indices 0.
- Start sampled at edge T → RUN from T; the first beat is possible in cycle T+1.
- `p_valid_output` follows its beat by 1 cycle and lasts 1 cycle.
- Final beat at cycle N: at N+1 `p_valid_output`=`last_chanel_output`=`end_conv`=1 and `busy`=1. At N+2 the FSM is IDLE and a new start can be sampled.
- With no stalls, a run is KTAPS·(ci+1)·(co+1)+1 cycles from the first beat to `end_conv`.

## Configuration
- `PE_CTRL_PERF_EN` defined: adds output `stall_cnt` [15:0].
  - Counts RUN cycles with `in_ready`=0.
  - Saturates at 16'hFFFF.
  - Cleared on entry to RUN.
  - Holds its value in IDLE/DONE.
  - Reset value 0.
- Not defined: `stall_cnt` port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset mid-RUN (assert `rst` asynchronously between edges) → all outputs 0 immediately, `busy`=0, then `start_again` is ignored (`cfg_loaded`=0).
- KTAPS=9, `cfg_ci`=1, `cfg_co`=2, `in_ready`=1 → 54 read beats, 6 `p_valid_output` pulses, 3 of them with `last_chanel_output`, then one `end_conv` coinciding with the 6th `p_valid_output`.
- Same config, `in_ready` toggling 1,0 → 54 beats over 108 cycles, indices hold during stalls; with `PE_CTRL_PERF_EN`, `stall_cnt`=54 at `end_conv`.
- `cfg_ci`=0, `cfg_co`=0, KTAPS=1 → single beat, then `p_valid_output`=`last_chanel_output`=`end_conv`=1 in the following cycle.
- `abort` asserted in the final beat cycle → no `end_conv`, no `p_valid_output`, IDLE next cycle; `start_again` then replays the same 54 beats.
- `start_conv` with a new config during RUN → ignored; the beat count matches the original config.
